gigex_rx_cmd_router: RTL and testbench
======================================

Name: gigex_rx_cmd_router

Overview:
- Receive-side counterpart to the GigEx transmit path.
- Accepts the GigEx user-channel byte stream (Q/nRx/RC) and controls the per-channel Rx-full flags (nRF).
- Assembles 4-byte big-endian command words and routes each word to one or all frontend command streams.
- Sits between the GigEx Rx port and the per-module command inputs that feed the reset controller / control TX path.

Parameters:
NMODULES, 4, number of frontend command outputs (max 15)
CMD_LEN, 32, command word width (fixed 4 bytes)
CMD_CHANNEL, 0, GigEx channel carrying commands (0-7)
FIFO_DEPTH, 16, byte skid FIFO depth (power of 2)
FULL_MARGIN, 4, free-entry threshold at which nRF[CMD_CHANNEL] asserts
TIMEOUT, 1024, idle cycles before a partial word is discarded

Ports:
clk  in  1  system clock (clk_100 domain)
rst  in  1  reset, asynchronous, active-low
Q  in  8  Rx byte from GigEx
nRx  in  1  Rx byte valid, active low
RC  in  3  Rx byte channel
nRF  out  8  Rx FIFO full per channel, active low
cmd_data  out  CMD_LEN  command word, shared by all outputs
cmd_valid  out  NMODULES  per-module valid
cmd_ready  in  NMODULES  per-module ready
bad_dest  out  1  one-cycle pulse, word had an invalid module index
frame_timeout  out  1  one-cycle pulse, partial word discarded
bytes_dropped  out  16  saturating count of bytes lost to FIFO overflow
words_dropped  out  16  saturating count of bad_dest plus frame_timeout events

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO empty, byte count 0, state IDLE.
  - cmd_valid=0, cmd_data=0, pulses=0, counters=0.
  - nRF=8'hFF.
- Byte capture:
  - Each rising edge with nRx=0 and RC==CMD_CHANNEL writes Q into the byte FIFO.
  - Bytes on other channels are ignored.
  - If the FIFO is full, the byte is dropped and bytes_dropped increments; it saturates at 16'hFFFF.
- Flow control:
  - nRF[CMD_CHANNEL] is registered.
  - It is driven 0 when free entries <= FULL_MARGIN, otherwise 1.
  - nRF is 1 for all other channels.
- FIFO:
  - Synchronous, first-word fall-through.
  - A byte written on edge k is poppable at edge k+1.
  - Simultaneous push and pop when full: the push is accepted.
- State machine:
  - IDLE / ASSEMBLE: pop one byte per cycle while the FIFO is non-empty. Shift it in MSB first: word = {word[23:0], byte}. Increment the count (0..3). Go to ASSEMBLE on the first byte.
  - 4th byte popped: latch the word into cmd_data and compute the destination from dest = word[31:28]:
    - dest < NMODULES: pending = one-hot(dest).
    - dest == 4'hF: pending = all ones (broadcast).
    - Otherwise: pending = 0, bad_dest pulses, words_dropped increments.
  - Next state is DISPATCH if pending != 0, else IDLE.
  - DISPATCH:
    - cmd_valid = pending; no pops.
    - On each edge, clear pending[i] where cmd_valid[i] & cmd_ready[i].
    - When pending becomes 0, go to IDLE. Popping resumes the following cycle.
    - cmd_data is stable throughout DISPATCH.
- Latency: four back-to-back bytes sampled at edges k..k+3 give cmd_valid high after edge k+5.
- Throughput: one word per 5 cycles when outputs are always ready.
- Timeout:
  - In ASSEMBLE, a counter increments each cycle in which the FIFO is empty.
  - The counter resets on any pop.
  - When it reaches TIMEOUT: discard the partial word, count=0, go to IDLE, pulse frame_timeout, increment words_dropped.
- Broadcast handshakes may complete on different cycles; each module sees exactly one handshake.
- A reset mid-DISPATCH drops the word with no pulse.

Optional Feature:
- Macro: GIGEX_RX_CMD_STATS_EN.
- Defined: bytes_dropped and words_dropped are live saturating counters.
- Undefined: both are tied to 16'h0, no counter logic is built, and bad_dest / frame_timeout pulses are unchanged.

Test Plan:
- Single unicast: bytes 8'h20,8'h00,8'h12,8'h34 on channel 0, all ready=1 -> cmd_valid=4'b0100 for exactly one cycle, cmd_data=32'h20001234, 5 cycles after the first byte.
- Broadcast with staggered ready: word 32'hF0000001; ready[0] at +0, ready[3] at +7, others at +3 -> each valid bit drops on its own handshake, state returns to IDLE after the last one, no re-issue.
- Backpressure: ready=0, 20 bytes streamed -> nRF[0]=0 once free <= 4; with the GigEx stopping 2 cycles late, no byte is lost (bytes_dropped=0); releasing ready drains 5 words in order.
- Bad destination and other channel: word 32'h70000000 plus bytes on RC=3 -> bad_dest one pulse, words_dropped=1, no cmd_valid, RC=3 bytes have no effect.
- Timeout: 3 bytes then TIMEOUT idle cycles -> frame_timeout pulse, following 4 bytes 8'h10,0,0,8'h05 -> cmd_data=32'h10000005 on module 1.
- Reset mid-assembly: 2 bytes, rst=0 for 1 cycle -> cmd_valid=0, nRF=8'hFF, the next 4 bytes form a clean word.

Source files
------------

// File: rtl/gigex_rx_cmd_router.sv
// GigEx Rx command router: byte FIFO -> 4-byte word assembly -> per-module valid/ready; GIGEX_RX_CMD_STATS_EN adds drop counters.
// Latency: bytes sampled at edges k..k+3 give cmd_valid after edge k+5; one word per 5 cycles when outputs are ready.
// Backpressure: a word is held until every addressed cmd_ready handshakes; nRF[CMD_CHANNEL] throttles the GigEx.

module gigex_rx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             pop_dat,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count_nxt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          do_pop, do_push;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is still taken when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + 1'b1;
    else if (!do_push && do_pop)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_dat;
  end
endmodule

module gigex_rx_cmd_router #(
  parameter int NMODULES    = 4,
  parameter int CMD_LEN     = 32,
  parameter int CMD_CHANNEL = 0,
  parameter int FIFO_DEPTH  = 16,
  parameter int FULL_MARGIN = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          Q,
  input  logic                nRx,
  input  logic [2:0]          RC,
  output logic [7:0]          nRF,
  output logic [CMD_LEN-1:0]  cmd_data,
  output logic [NMODULES-1:0] cmd_valid,
  input  logic [NMODULES-1:0] cmd_ready,
  output logic                bad_dest,
  output logic                frame_timeout,
  output logic [15:0]         bytes_dropped,
  output logic [15:0]         words_dropped
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] NRF_THR = CW'(FIFO_DEPTH - FULL_MARGIN);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ASSEMBLE, DISPATCH} state_t;

  state_t              state;
  logic                in_vld;
  logic [7:0]          in_dat;
  logic                nrf_cmd;
  logic [7:0]          fifo_dat;
  logic                fifo_empty, fifo_full, pop;
  logic [CW-1:0]       fifo_cnt_nxt;
  logic [CMD_LEN-9:0]  word;
  logic [CMD_LEN-1:0]  nxt_word;
  logic [1:0]          byte_cnt;
  logic [TW-1:0]       tmo_cnt;
  logic [NMODULES-1:0] pending, pending_nxt, dest_mask;
  logic [3:0]          dest;
  logic                dest_bad, tmo_evt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_vld  <= 1'b0;
      in_dat  <= '0;
      nrf_cmd <= 1'b1;
    end else begin
      in_vld  <= !nRx && (RC == 3'(CMD_CHANNEL));
      in_dat  <= Q;
      nrf_cmd <= (fifo_cnt_nxt < NRF_THR);
    end
  end

  always_comb begin
    nRF = 8'hFF;
    nRF[CMD_CHANNEL] = nrf_cmd;
  end

  gigex_rx_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_vld),
    .push_dat  (in_dat),
    .pop       (pop),
    .pop_dat   (fifo_dat),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count_nxt (fifo_cnt_nxt)
  );

  assign pop         = !fifo_empty && (state != DISPATCH);
  assign nxt_word    = {word, fifo_dat};
  assign dest        = nxt_word[CMD_LEN-1 -: 4];
  assign cmd_valid   = pending;
  assign pending_nxt = pending & ~cmd_ready;
  assign tmo_evt     = (state == ASSEMBLE) && fifo_empty && (tmo_cnt == TMO_LAST);

  always_comb begin
    dest_mask = '0;
    for (int i = 0; i < NMODULES; i++)
      if (dest == 4'(i)) dest_mask[i] = 1'b1;
    if (dest == 4'hF) dest_mask = '1;
  end
  assign dest_bad = (dest_mask == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      word          <= '0;
      byte_cnt      <= '0;
      tmo_cnt       <= '0;
      pending       <= '0;
      cmd_data      <= '0;
      bad_dest      <= 1'b0;
      frame_timeout <= 1'b0;
    end else begin
      bad_dest      <= 1'b0;
      frame_timeout <= 1'b0;
      case (state)
        IDLE, ASSEMBLE: begin
          if (!fifo_empty) begin
            word    <= nxt_word[CMD_LEN-9:0];
            tmo_cnt <= '0;
            if (byte_cnt == 2'd3) begin
              byte_cnt <= '0;
              cmd_data <= nxt_word;
              pending  <= dest_mask;
              bad_dest <= dest_bad;
              state    <= dest_bad ? IDLE : DISPATCH;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              state    <= ASSEMBLE;
            end
          end else if (state == ASSEMBLE) begin
            if (tmo_evt) begin
              word          <= '0;
              byte_cnt      <= '0;
              tmo_cnt       <= '0;
              frame_timeout <= 1'b1;
              state         <= IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
        end
        DISPATCH: begin
          pending <= pending_nxt;
          if (pending_nxt == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GIGEX_RX_CMD_STATS_EN
  logic [15:0] bytes_drop_q, words_drop_q;
  logic        byte_drop, bad_evt;

  assign byte_drop = in_vld && fifo_full && !pop;
  assign bad_evt   = pop && (byte_cnt == 2'd3) && dest_bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bytes_drop_q <= '0;
      words_drop_q <= '0;
    end else begin
      if (byte_drop && bytes_drop_q != 16'hFFFF)
        bytes_drop_q <= bytes_drop_q + 1'b1;
      if ((bad_evt || tmo_evt) && words_drop_q != 16'hFFFF)
        words_drop_q <= words_drop_q + 1'b1;
    end
  end

  assign bytes_dropped = bytes_drop_q;
  assign words_dropped = words_drop_q;
`else
  logic stats_unused;
  assign stats_unused  = fifo_full;
  assign bytes_dropped = 16'h0;
  assign words_dropped = 16'h0;
`endif
endmodule

// File: tb/tb_gigex_rx_cmd_router.sv
// Directed bench for gigex_rx_cmd_router; drop-counter expectations follow GIGEX_RX_CMD_STATS_EN.
module tb_gigex_rx_cmd_router;
    localparam int TMO = 32;
`ifdef GIGEX_RX_CMD_STATS_EN
    localparam logic [15:0] WD1 = 16'd1;
    localparam logic [15:0] WD2 = 16'd2;
`else
    localparam logic [15:0] WD1 = 16'd0;
    localparam logic [15:0] WD2 = 16'd0;
`endif

    logic        clk_100 = 1'b0;
    logic        rst;
    logic [7:0]  Q;
    logic        nRx;
    logic [2:0]  RC;
    logic [7:0]  nRF;
    logic [31:0] cmd_data;
    logic [3:0]  cmd_valid;
    logic [3:0]  cmd_ready;
    logic        bad_dest, frame_timeout;
    logic [15:0] bytes_dropped, words_dropped;

    int n_chk = 0;
    int n_pass = 0;
    int hs_cnt [4];
    int hs_base [4];
    int bad_seen = 0;
    int tmo_seen = 0;
    logic [35:0] log_q [$];

    always #5 clk_100 = ~clk_100;

    gigex_rx_cmd_router #(.TIMEOUT(TMO)) dut (
        .clk           (clk_100),
        .rst           (rst),
        .Q             (Q),
        .nRx           (nRx),
        .RC            (RC),
        .nRF           (nRF),
        .cmd_data      (cmd_data),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .bad_dest      (bad_dest),
        .frame_timeout (frame_timeout),
        .bytes_dropped (bytes_dropped),
        .words_dropped (words_dropped)
    );

    always @(posedge clk_100) begin
        if (bad_dest) bad_seen++;
        if (frame_timeout) tmo_seen++;
        for (int i = 0; i < 4; i++)
            if (cmd_valid[i] && cmd_ready[i]) begin
                hs_cnt[i]++;
                log_q.push_back({4'(i), cmd_data});
            end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_100);
    endtask

    // Drives the first n bytes of w (MSB first), one per edge, then idles the bus.
    task automatic send_n(input logic [31:0] w, input int n, input logic [2:0] ch);
        for (int i = 0; i < n; i++) begin
            Q   = w[31-8*i -: 8];
            RC  = ch;
            nRx = 1'b0;
            @(negedge clk_100);
        end
        nRx = 1'b1;
    endtask

    initial begin
        int base_log, base_bad, base_tmo;
        int sent, grace, stall, guard;
        bit released;

        rst = 1'b0; Q = '0; nRx = 1'b1; RC = '0; cmd_ready = '0;
        tick(3);
        chk("rst_valid", cmd_valid, 4'b0000);
        chk("rst_data", cmd_data, 32'h0);
        chk("rst_nrf", nRF, 8'hFF);
        chk("rst_bad", bad_dest, 1'b0);
        chk("rst_tmo", frame_timeout, 1'b0);
        chk("rst_bdrop", bytes_dropped, 16'h0);
        chk("rst_wdrop", words_dropped, 16'h0);
        rst = 1'b1;
        tick(2);

        // Single unicast to module 2
        cmd_ready = 4'b1111;
        send_n(32'h20001234, 4, 3'd0);
        tick(1);
        chk("uni_early", cmd_valid, 4'b0000);
        tick(1);
        chk("uni_valid", cmd_valid, 4'b0100);
        chk("uni_data", cmd_data, 32'h20001234);
        tick(1);
        chk("uni_once", cmd_valid, 4'b0000);

        // Broadcast with staggered ready
        tick(2);
        for (int i = 0; i < 4; i++) hs_base[i] = hs_cnt[i];
        cmd_ready = 4'b0001;
        send_n(32'hF0000001, 4, 3'd0);
        tick(2);
        chk("bc_valid", cmd_valid, 4'b1111);
        chk("bc_data", cmd_data, 32'hF0000001);
        tick(1);
        chk("bc_p1", cmd_valid, 4'b1110);
        tick(2);
        chk("bc_p3", cmd_valid, 4'b1110);
        cmd_ready = 4'b0111;
        tick(1);
        chk("bc_p4", cmd_valid, 4'b1000);
        tick(3);
        chk("bc_p7", cmd_valid, 4'b1000);
        chk("bc_hold", cmd_data, 32'hF0000001);
        cmd_ready = 4'b1111;
        tick(1);
        chk("bc_done", cmd_valid, 4'b0000);
        tick(3);
        chk("bc_noreissue", cmd_valid, 4'b0000);
        for (int i = 0; i < 4; i++) chk("bc_hs_once", hs_cnt[i] - hs_base[i], 1);

        // Backpressure: 5 words to module 2, sender stops two bytes after nRF drops
        cmd_ready = 4'b0000;
        base_log = log_q.size();
        chk("bp_nrf_open", nRF, 8'hFF);
        sent = 0; grace = 2; stall = 0; guard = 0; released = 1'b0;
        while (sent < 20 && guard < 300) begin
            if (nRF[0] == 1'b0 && grace == 0) begin
                nRx = 1'b1;
                stall++;
                if (!released && stall == 5) begin
                    chk("bp_nrf_full", nRF, 8'hFE);
                    chk("bp_hold_valid", cmd_valid, 4'b0100);
                    chk("bp_no_drop", bytes_dropped, 16'h0);
                    cmd_ready = 4'b1111;
                    released = 1'b1;
                end
            end else begin
                if (nRF[0] == 1'b0) grace--; else grace = 2;
                Q   = (sent % 4 == 0) ? 8'h20 : (sent % 4 == 3) ? 8'(sent / 4) : 8'h00;
                RC  = 3'd0;
                nRx = 1'b0;
                sent++;
            end
            @(negedge clk_100);
            guard++;
        end
        nRx = 1'b1;
        chk("bp_sent", sent, 20);
        chk("bp_throttled", released, 1'b1);
        cmd_ready = 4'b1111;
        tick(60);
        chk("bp_count", log_q.size() - base_log, 5);
        for (int i = 0; i < 5; i++)
            chk("bp_word", log_q[base_log + i], {4'd2, 32'h20000000 | 32'(i)});
        chk("bp_drop_end", bytes_dropped, 16'h0);
        chk("bp_nrf_end", nRF, 8'hFF);

        // Bad destination plus traffic on another channel
        base_log = log_q.size();
        base_bad = bad_seen;
        send_n(32'h10000001, 4, 3'd3);
        send_n(32'h70000000, 4, 3'd0);
        tick(8);
        chk("bad_pulse", bad_seen - base_bad, 1);
        chk("bad_novalid", log_q.size() - base_log, 0);
        chk("bad_wdrop", words_dropped, WD1);
        send_n(32'h30000042, 4, 3'd0);
        tick(2);
        chk("bad_next_valid", cmd_valid, 4'b1000);
        chk("bad_next_data", cmd_data, 32'h30000042);

        // Timeout on a 3-byte partial word
        tick(3);
        base_tmo = tmo_seen;
        send_n(32'hAABBCC00, 3, 3'd0);
        tick(TMO + 1);
        chk("tmo_early", frame_timeout, 1'b0);
        tick(1);
        chk("tmo_pulse", frame_timeout, 1'b1);
        tick(1);
        chk("tmo_single", frame_timeout, 1'b0);
        chk("tmo_count", tmo_seen - base_tmo, 1);
        chk("tmo_wdrop", words_dropped, WD2);
        send_n(32'h10000005, 4, 3'd0);
        tick(2);
        chk("tmo_next_valid", cmd_valid, 4'b0010);
        chk("tmo_next_data", cmd_data, 32'h10000005);

        // Reset in the middle of assembly
        tick(3);
        send_n(32'hABCD0000, 2, 3'd0);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        chk("mid_rst_valid", cmd_valid, 4'b0000);
        chk("mid_rst_nrf", nRF, 8'hFF);
        chk("mid_rst_wdrop", words_dropped, 16'h0);
        tick(1);
        send_n(32'h00ABCDEF, 4, 3'd0);
        tick(2);
        chk("mid_rst_word_valid", cmd_valid, 4'b0001);
        chk("mid_rst_word_data", cmd_data, 32'h00ABCDEF);
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
